// File: rtl/stack_cmd_master.sv
// ---------------------------------------------------------------------------
// stack_cmd_master
//
// Processor-side master for the LIFO stack block. Accepts one core command
// at a time (PUSH, POP, CALL, RET), turns it into a correctly timed stack
// transaction and returns exactly one response through a valid/ready
// handshake. CALL pushes the return address (cmd_pc+1) and jumps to
// cmd_data; RET pops the return address and jumps to it.
//
// The master keeps its own occupancy count, so overflow and underflow are
// detected at accept time and no stack access is made for a failing command.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high; the stack is reset in the
//                      same cycle
//   cmd_valid     in   command present
//   cmd_ready     out  master can accept a command (high only in IDLE)
//   cmd_op        in   00 PUSH, 01 POP, 10 CALL, 11 RET
//   cmd_data      in   PUSH operand / CALL target
//   cmd_pc        in   PC of the CALL instruction
//   resp_valid    out  response present
//   resp_ready    in   consumer accepts response
//   resp_data     out  popped word (POP/RET), pushed word (PUSH/CALL), 0 on error
//   resp_err      out  overflow (PUSH/CALL) or underflow (POP/RET)
//   pc_load       out  one-cycle pulse: load pc_value into the PC
//   pc_value      out  jump target, holds its last value otherwise
//   stk_push      out  stack push strobe
//   stk_pop       out  stack pop strobe
//   stk_data_in   out  word to push
//   stk_data_out  in   stack read data, valid the cycle after stk_pop
//   stk_full      in   stack full flag
//   stk_empty     in   stack empty flag
//   depth         out  current occupancy (0..DEPTH)
//
// Latency from the accept edge to resp_valid: PUSH/CALL 2 cycles,
// POP/RET 3 cycles, error 1 cycle.
// ---------------------------------------------------------------------------
module stack_cmd_master #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 10,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH_DATA-1:0] cmd_data,
    input  logic [WIDTH_DATA-1:0] cmd_pc,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH_DATA-1:0] resp_data,
    output logic                  resp_err,

    output logic                  pc_load,
    output logic [WIDTH_DATA-1:0] pc_value,

    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH_DATA-1:0] stk_data_in,
    input  logic [WIDTH_DATA-1:0] stk_data_out,
    input  logic                  stk_full,
    input  logic                  stk_empty,

    output logic [CW-1:0]         depth
);

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DO_PUSH,
        S_DO_POP,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    op_t                     op_q;
    logic [WIDTH_DATA-1:0]   target_q;

    // PUSH and CALL both write the stack; they differ from POP/RET in bit 0.
    logic                    is_write_op;
    logic                    overflow;
    logic                    underflow;
    logic                    cmd_err;

    assign is_write_op = ~cmd_op[0];
    // Both our own count and the stack's flag are honoured, so a mismatch
    // between the two can never cause a push into a full stack or a pop
    // from an empty one.
    assign overflow    = (depth == CW'(DEPTH)) || stk_full;
    assign underflow   = (depth == '0) || stk_empty;
    assign cmd_err     = is_write_op ? overflow : underflow;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and handshake/strobe outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_err) begin
                        state_next = S_RESP;
                    end else if (is_write_op) begin
                        state_next = S_DO_PUSH;
                    end else begin
                        state_next = S_DO_POP;
                    end
                end
            end

            S_DO_PUSH: begin
                stk_push   = 1'b1;
                state_next = S_RESP;
            end

            S_DO_POP: begin
                stk_pop    = 1'b1;
                state_next = S_CAPTURE;
            end

            // Stack read data is registered; it is valid in this cycle.
            S_CAPTURE: begin
                state_next = S_RESP;
            end

            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: latched command, occupancy, response and PC outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_PUSH;
            target_q    <= '0;
            depth       <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            pc_load     <= 1'b0;
            pc_value    <= '0;
            stk_data_in <= '0;
        end else begin
            // pc_load is a single-cycle pulse; it is only re-armed on the
            // transition into RESP below.
            pc_load <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        target_q  <= cmd_data;
                        resp_err  <= cmd_err;
                        resp_data <= '0;
                        if (!cmd_err && is_write_op) begin
                            // CALL pushes its return address, wrapping at
                            // the top of the address space.
                            stk_data_in <= (op_t'(cmd_op) == OP_CALL)
                                         ? cmd_pc + WIDTH_DATA'(1)
                                         : cmd_data;
                        end
                    end
                end

                S_DO_PUSH: begin
                    depth     <= depth + CW'(1);
                    resp_data <= stk_data_in;
                    if (op_q == OP_CALL) begin
                        pc_load  <= 1'b1;
                        pc_value <= target_q;
                    end
                end

                S_DO_POP: begin
                    depth <= depth - CW'(1);
                end

                S_CAPTURE: begin
                    resp_data <= stk_data_out;
                    if (op_q == OP_RET) begin
                        pc_load  <= 1'b1;
                        pc_value <= stk_data_out;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Simulation-only protocol checks
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    a_strobe_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(stk_push && stk_pop)
    );

    a_depth_range: assert property (
        @(posedge clk) disable iff (reset) depth <= CW'(DEPTH)
    );

    a_resp_stable: assert property (
        @(posedge clk) disable iff (reset)
        (resp_valid && !resp_ready) |=>
            (resp_valid && $stable(resp_data) && $stable(resp_err))
    );
`endif

endmodule

// File: tb/tb_stack_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_stack_cmd_master
//
// Self-checking bench for stack_cmd_master. A behavioural LIFO peripheral
// answers the master's strobes. The command driver computes each expected
// response from a queue-based model of the stack and pushes it into a
// scoreboard; an independent monitor pops and compares whenever the DUT
// completes a response handshake. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_stack_cmd_master;

    localparam int W      = 16;
    localparam int D      = 10;
    localparam int CW     = $clog2(D + 1);
    localparam int PERIOD = 10;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [W-1:0]  cmd_pc;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_data;
    logic          resp_err;
    logic          pc_load;
    logic [W-1:0]  pc_value;
    logic          stk_push;
    logic          stk_pop;
    logic [W-1:0]  stk_data_in;
    logic [W-1:0]  stk_data_out;
    logic          stk_full;
    logic          stk_empty;
    logic [CW-1:0] depth;

    stack_cmd_master #(
        .WIDTH_DATA (W),
        .DEPTH      (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_pc       (cmd_pc),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .depth        (depth)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Behavioural LIFO peripheral: registered read data, flags from count
    // -----------------------------------------------------------------------
    logic [W-1:0] mem [D];
    int           sp = 0;

    always @(posedge clk) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < D) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    assign stk_full  = (sp == D);
    assign stk_empty = (sp == 0);

    // -----------------------------------------------------------------------
    // Checking infrastructure
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        logic         pcl;
        logic [W-1:0] pcv;
        int           depth;
        int           lat;
        int           pushes;
        int           pops;
        longint       t_acc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mstk[$];
    logic [W-1:0] mpcv = '0;
    bit           bp_en = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, waits for it to be accepted and records what the
    // model says the response must be.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [W-1:0] pc, input bit expect_resp = 1'b1);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready) begin
            step();
            n++;
            if (n > 200) begin
                $display("FAIL cmd_ready_timeout: cmd_ready low for %0d cycles", n);
                $fatal(1, "cmd_ready never returned");
            end
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_pc    = pc;
        @(posedge clk);
        e.t_acc  = $time;
        e.err    = 1'b0;
        e.pcl    = 1'b0;
        e.pushes = 0;
        e.pops   = 0;
        if (op == OP_PUSH || op == OP_CALL) begin
            if (mstk.size() == D) begin
                e.err  = 1'b1;
                e.data = '0;
                e.lat  = 1;
            end else begin
                e.data = (op == OP_CALL) ? pc + 16'd1 : data;
                mstk.push_back(e.data);
                e.lat    = 2;
                e.pushes = 1;
                if (op == OP_CALL) begin
                    e.pcl = 1'b1;
                    mpcv  = data;
                end
            end
        end else begin
            if (mstk.size() == 0) begin
                e.err  = 1'b1;
                e.data = '0;
                e.lat  = 1;
            end else begin
                e.data = mstk.pop_back();
                e.lat  = 3;
                e.pops = 1;
                if (op == OP_RET) begin
                    e.pcl = 1'b1;
                    mpcv  = e.data;
                end
            end
        end
        e.pcv   = mpcv;
        e.depth = mstk.size();
        if (expect_resp) sb.push_back(e);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        check("rst_depth",       32'(depth),       32'd0);
        check("rst_resp_valid",  32'(resp_valid),  32'd0);
        check("rst_resp_err",    32'(resp_err),    32'd0);
        check("rst_pc_load",     32'(pc_load),     32'd0);
        check("rst_stk_push",    32'(stk_push),    32'd0);
        check("rst_stk_pop",     32'(stk_pop),     32'd0);
        check("rst_resp_data",   32'(resp_data),   32'd0);
        check("rst_pc_value",    32'(pc_value),    32'd0);
        check("rst_stk_data_in", 32'(stk_data_in), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 200) begin
            step();
            n++;
        end
        check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Monitor: strobes, response timing and response contents
    // -----------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        bit   first;
        int   push_cnt;
        int   pop_cnt;
        first    = 1'b1;
        push_cnt = 0;
        pop_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                first    = 1'b1;
                push_cnt = 0;
                pop_cnt  = 0;
            end else begin
                if (stk_push || stk_pop)
                    check("strobe_exclusive", 32'(stk_push & stk_pop), 32'd0);
                if (stk_push) begin
                    push_cnt++;
                    if (sb.size() > 0) check("push_data", 32'(stk_data_in), 32'(sb[0].data));
                    else               check("stray_push", 32'(stk_push), 32'd0);
                end
                if (stk_pop) pop_cnt++;

                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'(resp_valid), 32'd0);
                    end else begin
                        e = sb[0];
                        if (first) begin
                            check("latency", 32'(($time - e.t_acc + PERIOD / 2) / PERIOD),
                                  32'(e.lat));
                            check("pc_load_pulse", 32'(pc_load), 32'(e.pcl));
                            if (e.pcl) check("pc_value_jump", 32'(pc_value), 32'(e.pcv));
                            first = 1'b0;
                        end else begin
                            check("pc_load_single", 32'(pc_load), 32'd0);
                        end
                        check("resp_data", 32'(resp_data), 32'(e.data));
                        check("resp_err",  32'(resp_err),  32'(e.err));
                        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                        if (resp_ready) begin
                            check("push_pulses", 32'(push_cnt), 32'(e.pushes));
                            check("pop_pulses",  32'(pop_cnt),  32'(e.pops));
                            check("depth",       32'(depth),    32'(e.depth));
                            check("pc_value",    32'(pc_value), 32'(e.pcv));
                            void'(sb.pop_front());
                            first    = 1'b1;
                            push_cnt = 0;
                            pop_cnt  = 0;
                        end
                    end
                end else if (pc_load) begin
                    check("stray_pc_load", 32'(pc_load), 32'd0);
                end
            end
        end
    end

    // Random backpressure on the response channel when enabled.
    initial begin : backpressure
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stimulus
        int n;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = OP_PUSH;
        cmd_data   = '0;
        cmd_pc     = '0;
        resp_ready = 1'b1;
        repeat (3) step();
        check_reset_values();
        reset = 1'b0;

        // Basic push then pop.
        issue(OP_PUSH, 16'h1234, '0);
        issue(OP_POP, '0, '0);

        // Underflow on an empty stack.
        issue(OP_POP, 16'hDEAD, '0);

        // Fill, overflow, then empty in LIFO order.
        for (int i = 1; i <= D; i++) issue(OP_PUSH, W'(i), '0);
        issue(OP_PUSH, 16'hBEEF, '0);
        for (int i = 0; i < D; i++) issue(OP_POP, '0, '0);

        // CALL/RET, including return-address wrap.
        issue(OP_CALL, 16'h0200, 16'h0040);
        issue(OP_RET, '0, '0);
        issue(OP_CALL, 16'h0300, 16'hFFFF);
        issue(OP_RET, '0, '0);
        drain();

        // Response held by backpressure; a command in that window is ignored.
        issue(OP_PUSH, 16'h00AA, '0);
        issue(OP_POP, '0, '0);
        resp_ready = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        check("hold_resp_seen", 32'(resp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 16'h0077;
        repeat (5) begin
            step();
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_resp_data",  32'(resp_data),  32'h00AA);
            check("hold_cmd_ready",  32'(cmd_ready),  32'd0);
            check("hold_depth",      32'(depth),      32'(mstk.size()));
        end
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();

        // Reset in the DO_POP cycle abandons the command.
        issue(OP_PUSH, 16'h0055, '0);
        issue(OP_POP, '0, '0, 1'b0);
        check("abort_in_do_pop", 32'(stk_pop), 32'd1);
        reset = 1'b1;
        step();
        check_reset_values();
        reset = 1'b0;
        mstk.delete();
        mpcv = '0;
        repeat (6) begin
            step();
            check("no_resp_after_abort", 32'(resp_valid), 32'd0);
        end

        // Randomized traffic with backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [1:0]   op;
            logic [W-1:0] pc;
            op = 2'($urandom_range(0, 3));
            pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            issue(op, W'($urandom), pc);
        end
        bp_en      = 1'b0;
        resp_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_cmd_master.md
Name: stack_cmd_master

Overview:
- Processor-side master for the LIFO stack block. Drives its push/pop/data_in, samples its data_out/full/empty.
- Turns core commands into correctly timed stack transactions: PUSH, POP, CALL (push return address, jump) and RET (pop return address, jump).
- Returns one response per command through a valid/ready handshake.
- Sits between the control unit/PC logic and the stack. Keeps its own occupancy count, so overflow and underflow are caught before any stack access.

Parameters:
- WIDTH_DATA, 16, width of stack words, PC and command data.
- DEPTH, 10, stack capacity in words; must match the stack instance.
- CW, $clog2(DEPTH+1), occupancy counter width (local).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high. Must be applied to the stack in the same cycle.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- cmd_data  in  WIDTH_DATA  PUSH operand / CALL target; ignored for POP/RET.
- cmd_pc  in  WIDTH_DATA  PC of the CALL instruction.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  WIDTH_DATA  popped word (POP/RET), pushed word (PUSH/CALL), 0 on error.
- resp_err  out  1  overflow (PUSH/CALL) or underflow (POP/RET).
- pc_load  out  1  one-cycle pulse: load pc_value into PC.
- pc_value  out  WIDTH_DATA  jump target.
- stk_push  out  1  stack push strobe.
- stk_pop  out  1  stack pop strobe.
- stk_data_in  out  WIDTH_DATA  word to push.
- stk_data_out  in  WIDTH_DATA  stack read data. Registered; valid the cycle after stk_pop.
- stk_full  in  1  stack full flag.
- stk_empty  in  1  stack empty flag.
- depth  out  CW  current occupancy.

Behaviour:
- Reset values:
  - State IDLE, cmd_ready=1, depth=0.
  - resp_valid=0, resp_err=0, pc_load=0, stk_push=0, stk_pop=0.
  - resp_data=0, pc_value=0, stk_data_in=0.
- Reset has priority over everything. Reset mid-operation abandons the command; no response is produced.
- States:
  - IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready. Latch op, cmd_data, and cmd_pc+1 (mod 2^WIDTH_DATA).
  - Overflow: PUSH/CALL with depth==DEPTH or stk_full goes to RESP with resp_err=1.
  - Underflow: POP/RET with depth==0 or stk_empty goes to RESP with resp_err=1.
  - Otherwise PUSH/CALL goes to DO_PUSH and POP/RET goes to DO_POP.
  - DO_PUSH: stk_push=1 for exactly one cycle. stk_data_in = cmd_data (PUSH) or cmd_pc+1 (CALL). depth+1. Next state RESP.
  - DO_POP: stk_pop=1 for exactly one cycle. depth-1. Next state CAPTURE.
  - CAPTURE: register stk_data_out into resp_data. Next state RESP.
  - RESP: resp_valid=1. resp_data and resp_err stay stable until resp_ready is sampled high, then return to IDLE.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored.
- stk_push and stk_pop are never high in the same cycle, and never high outside DO_PUSH/DO_POP.
- pc_load: single-cycle pulse in the first RESP cycle, only for error-free CALL/RET.
  - CALL: pc_value = cmd_data.
  - RET: pc_value = popped word.
  - pc_value holds its last value otherwise.
- Latency from accept edge to resp_valid:
  - PUSH/CALL: 2 cycles.
  - POP/RET: 3 cycles.
  - Error: 1 cycle.
- Throughput: one command per 3 (push) / 4 (pop) cycles with resp_ready tied high.
- depth never leaves 0..DEPTH; error commands do not change it.

Test Plan:
- Reset, PUSH 0x1234 (resp_ready=1), then POP:
  - Single stk_push pulse 1 cycle after accept with stk_data_in=0x1234; resp_valid 2 cycles after accept; depth=1.
  - POP response resp_data=0x1234, resp_err=0, 3 cycles after accept; depth=0.
- POP right after reset -> resp_err=1, resp_data=0, no stk_pop pulse, no pc_load, depth stays 0.
- PUSH 1..10, then PUSH 0xBEEF -> 11th gives resp_err=1, no stk_push, depth=10. Ten POPs then return 10,9,...,1.
- CALL cmd_pc=0x0040, cmd_data=0x0200:
  - stk_data_in=0x0041, pc_load pulse with pc_value=0x0200.
  - RET -> pc_load pulse with pc_value=0x0041, resp_data=0x0041.
  - CALL with cmd_pc=0xFFFF pushes 0x0000.
- Hold resp_ready=0 for 5 cycles after a POP of 0x00AA -> resp_valid/resp_data=0x00AA stable, cmd_ready=0. A cmd_valid PUSH in that window is not accepted and depth is unchanged.
- Assert reset in the DO_POP cycle -> next cycle all outputs at reset values, depth=0, no resp_valid ever issued for that command.
